// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings and the sequencing states.
package md_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10,
      FIX  = 2'b11
   } md_state_t;

endpackage

// File: rtl/md_abs.sv
// Conditional two's-complement negate. Takes magnitudes of signed operands
// on the way in and restores the result sign on the way out.
module md_abs
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   // Negate only when asked; otherwise pass the value straight through.
   assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding HI/LO. Works on operand magnitudes
// (one bit per cycle, shift-add or restoring division) and fixes the sign of
// the result in a final cycle, so every operation has the same latency.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic            div_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   md_state_t         state;
   logic [CNT_W-1:0]  counter;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   divisor_mcand;
   logic              is_div;
   logic              q_sign;
   logic              r_sign;

   logic              op_div;
   logic              op_signed;
   logic [XLEN-1:0]   a_abs;
   logic [XLEN-1:0]   b_abs;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_part;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;

   assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);

   md_abs #(.WIDTH(XLEN)) u_abs_a (
      .value  (a),
      .negate (op_signed & a[XLEN-1]),
      .result (a_abs)
   );

   md_abs #(.WIDTH(XLEN)) u_abs_b (
      .value  (b),
      .negate (op_signed & b[XLEN-1]),
      .result (b_abs)
   );

   md_abs #(.WIDTH(2*XLEN)) u_fix_prod (
      .value  (acc),
      .negate (q_sign),
      .result (prod_fix)
   );

   md_abs #(.WIDTH(XLEN)) u_fix_quo (
      .value  (acc[XLEN-1:0]),
      .negate (q_sign),
      .result (quo_fix)
   );

   md_abs #(.WIDTH(XLEN)) u_fix_rem (
      .value  (acc[2*XLEN-1:XLEN]),
      .negate (r_sign),
      .result (rem_fix)
   );

   // One iteration of each algorithm: the multiply adds the multiplicand into
   // the upper half when the next multiplier bit is set; the divide shifts the
   // next dividend bit into the partial remainder and trial-subtracts.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} +
                 (acc[0] ? {1'b0, divisor_mcand} : {(XLEN+1){1'b0}});
      div_part = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff = div_part - {1'b0, divisor_mcand};
   end

   // Sequencer and datapath registers: capture, iterate, fix sign, report.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         counter       <= '0;
         acc           <= '0;
         divisor_mcand <= '0;
         is_div        <= 1'b0;
         q_sign        <= 1'b0;
         r_sign        <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         div_zero      <= 1'b0;
         hi            <= '0;
         lo            <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         if (flush && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !flush) begin
                     if (op_div && b == '0) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                     end else begin
                        acc           <= {{XLEN{1'b0}}, a_abs};
                        divisor_mcand <= b_abs;
                        is_div        <= op_div;
                        q_sign        <= op_signed & (a[XLEN-1] ^ b[XLEN-1]);
                        r_sign        <= op_signed & a[XLEN-1];
                        counter       <= CNT_W'(XLEN);
                        busy          <= 1'b1;
                        state         <= op_div ? DIV : MUL;
                     end
                  end
               end
               MUL: begin
                  acc     <= {mul_sum, acc[XLEN-1:1]};
                  counter <= counter - CNT_W'(1);
                  if (counter == CNT_W'(1)) begin
                     state <= FIX;
                  end
               end
               DIV: begin
                  if (!div_diff[XLEN]) begin
                     acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                  end else begin
                     acc <= {div_part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                  end
                  counter <= counter - CNT_W'(1);
                  if (counter == CNT_W'(1)) begin
                     state <= FIX;
                  end
               end
               FIX: begin
                  if (is_div) begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end else begin
                     hi <= prod_fix[2*XLEN-1:XLEN];
                     lo <= prod_fix[XLEN-1:0];
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit feeding the HI/LO registers of the multicycle CPU.
- Generalises the fixed 32-bit single-cycle ALU path. Provides signed and unsigned multiply and divide at width XLEN, with a start/done handshake the control FSM waits on.
- Adds divide-by-zero detection for the exception path (EPC) and a flush input for cancelling an operation.

Parameters:
- XLEN, 32, operand width; HI/LO are each XLEN bits.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (op[1]=divide, op[0]=unsigned)
- a  input  XLEN  operand A (rs); captured on start
- b  input  XLEN  operand B (rt); captured on start
- flush  input  1  abort current operation; HI/LO not written
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result or exception is valid
- div_zero  output  1  one-cycle pulse with done; divide by zero
- hi  output  XLEN  HI register (product high half / remainder)
- lo  output  XLEN  LO register (product low half / quotient)

Behaviour:
- Reset: when reset==0 at a rising edge, state=IDLE and busy=done=div_zero=0, hi=lo=0, counter=0. Reset takes effect mid-operation the same way; the partial result is discarded.
- States: IDLE, MUL, DIV, FIX. All outputs are registered.
- IDLE with start=1, op divide, b==0:
  - Next cycle: done=1, div_zero=1.
  - HI/LO unchanged; stay IDLE; busy stays 0.
- IDLE with start=1 otherwise:
  - Capture |a| and |b| (two's-complement magnitude if signed and negative, else raw).
  - Record the result sign: a^b for product/quotient; sign of a for remainder.
  - counter=XLEN, busy=1; go to MUL or DIV.
- MUL: shift-add, one bit per cycle, over a 2*XLEN accumulator. Decrement counter; at 0 go to FIX.
- DIV: restoring division, one quotient bit per cycle: remainder-partial minus divisor, keep if non-negative. Decrement counter; at 0 go to FIX.
- FIX:
  - Apply sign correction and write hi/lo.
  - done=1 (one cycle); busy=0; go to IDLE.
- Latency: start sampled at edge 0; hi/lo valid and done=1 after edge XLEN+1. Total XLEN+2 cycles start-to-done, identical for all ops.
- Signed overflow MIN/-1: lo=MIN (0x80000000 for XLEN=32), hi=0. No exception.
- Remainder sign follows dividend; quotient truncates toward zero.
- start while busy: ignored, no queueing. Control must wait for done.
- flush while busy: next state IDLE, busy=0, no done pulse, HI/LO keep old values.
- flush in IDLE: no effect.
- flush and start in the same IDLE cycle: flush wins; nothing is started.
- hi/lo are stable except in the FIX cycle and on reset.

Decomposition:
- Shared package md_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum md_state_t {IDLE, MUL, DIV, FIX}.
- One natural sub-module: md_abs (combinational conditional two's-complement negate, width XLEN). It is used for the input magnitudes and for the output sign fixup.
- FSM and datapath stay in mult_div_unit.

Test Plan:
- MULT, a=0xFFFFFFFD (-3), b=7 -> done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for cycles 1..33.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, a=100, b=7 -> lo=14, hi=2.
- DIV with b=0 after a prior result hi=0x12, lo=0x34 -> done=div_zero=1 one cycle after start; busy never high; hi/lo remain 0x12/0x34.
- DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Mid-operation disturbances:
  - flush at cycle 10 of a MULT -> busy drops next cycle, no done, hi/lo unchanged.
  - start pulsed at cycle 5 of a DIV -> ignored; the original result is correct.
  - reset=0 at cycle 12 -> all outputs 0.
